bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Consumes the 12-bit packed BCD value (hundreds/tens/units) produced by the binary-to-BCD converter.
- Drives a 4-digit, common-anode, multiplexed 7-segment display for the greenhouse readouts.
- Digits 0-2 show the reading. Digit 3 shows a unit symbol (C/F/H).
- Holds the value in a pending/display register pair so a new value is only shown from the start of a scan frame, which avoids tearing.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit; must be >= 2.
- CNT_W, 16, width of the refresh divider counter; must satisfy 2**CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- bcd_in  in  12  {hundreds[11:8], tens[7:4], units[3:0]}
- load  in  1  one-cycle strobe; capture bcd_in, unit_sel, dp_en, lz_en
- unit_sel  in  2  0 blank, 1 'C', 2 'F', 3 'H'
- dp_en  in  1  light the decimal point on digit 1 (tens), giving xx.x format
- lz_en  in  1  enable leading-zero blanking
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  4  digit anodes, active-low; an[0] = units, an[3] = unit symbol

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low. All state changes on the rising edge of clk.
- Reset values:
  - seg = 7'h7F, dp = 1, an = 4'hF.
  - div_cnt = 0, digit_idx = 3.
  - Pending and display registers = 0; pending_valid = 0.
- Reset mid-scan forces the reset values on the next edge.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1.
  - tick = (div_cnt == REFRESH_DIV-1). On tick, div_cnt wraps to 0.
- Scan:
  - On tick, digit_idx increments mod 4.
  - In the same edge, an/seg/dp are registered from the NEW index. Outputs and index are never skewed.
  - First lit digit is digit 0, REFRESH_DIV cycles after reset release.
- Frame boundary = tick while digit_idx == 3 (3 -> 0 wrap).
- Load, not at a frame boundary: capture all inputs into the pending register and set pending_valid. A later load before the boundary overwrites pending (last wins).
- At a frame boundary:
  - If load is asserted in this cycle, bcd_in and the other inputs go directly to the display register, and pending_valid clears.
  - Otherwise, if pending_valid, pending is copied to display and pending_valid clears.
  - In both cases digit 0 of the new frame already uses the new display value.
- Nibble decode (active-low), 0-9: 40,79,24,30,19,12,02,78,00,10 (hex). Nibble > 9 gives '-' = 7'h3F.
- Unit digit: C = 7'h46, F = 7'h0E, H = 7'h09, blank = 7'h7F.
- Leading-zero blanking (lz_en latched = 1):
  - Hundreds blank (7'h7F) if its nibble == 0.
  - Tens blank if hundreds == 0 AND tens == 0, and dp_en == 0.
  - Units never blanked.
  - An invalid nibble counts as non-zero.
- dp = 0 only while digit 1 is active and the latched dp_en = 1. Otherwise dp = 1.
- An blanked digit still has its anode asserted, with seg = 7'h7F.

Decomposition:
- Shared package seg7_pkg holds:
  - localparams for segment patterns: SEG_0..SEG_9, SEG_DASH, SEG_BLANK, SEG_C, SEG_F, SEG_H.
  - UNIT_* codes for unit_sel.
- Sub-module seg7_decode is combinational. It takes a 4-bit nibble plus a blank flag and returns the 7-bit active-low pattern.
- bcd_display_scan instantiates seg7_decode once on the muxed nibble. The unit symbol is chosen by a separate mux.

Test Plan (REFRESH_DIV=4):
- Reset held 3 cycles, then released -> seg=7'h7F, an=4'hF, dp=1 until the 4th cycle. Then an=4'b1110 with seg=7'h40 (display = 000, lz_en=0).
- load bcd_in=12'h123, unit_sel=1, lz_en=0 during frame -> no change until the next 3->0 wrap. Then the per-digit sequence is an 1110/1101/1011/0111 with seg 30/24/79/46, each held 4 cycles.
- load bcd_in=12'h005, lz_en=1, dp_en=0 -> hundreds and tens seg=7'h7F with anode asserted, units seg=7'h12. Repeat with dp_en=1 -> tens shows 7'h40, dp=0 only on an=4'b1101.
- load bcd_in=12'h1A3 -> tens digit seg=7'h3F. With lz_en=1 the hundreds still shows 7'h79.
- Two loads (12'h111, then 12'h222) mid-frame, plus a load of 12'h333 in the exact boundary cycle -> the next frame shows 333. A single mid-frame load of 12'h222 alone -> the next frame shows 222.
- rst_n low while digit 2 is active -> next edge gives an=4'hF, seg=7'h7F. The display value is cleared to 000 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Segment patterns, unit-symbol codes and the latched display configuration
// shared by the greenhouse 7-segment display scanner.
package seg7_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_H     = 7'h09;

    localparam logic [1:0] UNIT_BLANK = 2'd0;
    localparam logic [1:0] UNIT_C     = 2'd1;
    localparam logic [1:0] UNIT_F     = 2'd2;
    localparam logic [1:0] UNIT_H     = 2'd3;

    localparam logic [1:0] DIGIT_UNITS    = 2'd0;
    localparam logic [1:0] DIGIT_TENS     = 2'd1;
    localparam logic [1:0] DIGIT_HUNDREDS = 2'd2;
    localparam logic [1:0] DIGIT_UNIT_SYM = 2'd3;

    typedef struct packed {
        logic [11:0] bcd;
        logic [1:0]  unit_sel;
        logic        dp_en;
        logic        lz_en;
    } disp_cfg_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder; invalid
// nibbles show a dash, and the blank flag overrides everything.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every path assigns seg, and the default below covers the rest, so no latch is inferred.
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed display driver: three BCD digits plus a unit symbol,
// with new values applied only at a frame boundary so a frame never tears.
module bcd_display_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic [1:0]  unit_sel,
    input  logic        dp_en,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       digit_idx;
    logic [1:0]       next_idx;
    logic             tick;
    logic             frame_boundary;
    disp_cfg_t        load_cfg;
    disp_cfg_t        pending_q;
    logic             pending_valid;
    disp_cfg_t        display_q;
    disp_cfg_t        next_display;
    logic [3:0]       hundreds;
    logic [3:0]       tens;
    logic [3:0]       dec_nibble;
    logic             dec_blank;
    logic [6:0]       dec_seg;
    logic [6:0]       unit_seg;
    logic [6:0]       digit_seg;

    assign tick           = (div_cnt == DIV_LAST);
    assign frame_boundary = tick && (digit_idx == DIGIT_UNIT_SYM);
    assign next_idx       = digit_idx + 2'd1;
    assign load_cfg       = '{bcd: bcd_in, unit_sel: unit_sel, dp_en: dp_en, lz_en: lz_en};

    // A load landing on the boundary itself bypasses pending and wins.
    always_comb begin
        next_display = display_q;
        if (frame_boundary) begin
            if (load) begin
                next_display = load_cfg;
            end else if (pending_valid) begin
                next_display = pending_q;
            end
        end
    end

    assign hundreds = next_display.bcd[11:8];
    assign tens     = next_display.bcd[7:4];

    always_comb begin
        dec_nibble = next_display.bcd[3:0];
        dec_blank  = 1'b0;
        case (next_idx)
            DIGIT_TENS: begin
                dec_nibble = tens;
                dec_blank  = next_display.lz_en && (hundreds == 4'd0) && (tens == 4'd0)
                             && !next_display.dp_en;
            end
            DIGIT_HUNDREDS: begin
                dec_nibble = hundreds;
                dec_blank  = next_display.lz_en && (hundreds == 4'd0);
            end
            default: ;
        endcase
    end

    seg7_decode u_decode (
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        case (next_display.unit_sel)
            UNIT_C:  unit_seg = SEG_C;
            UNIT_F:  unit_seg = SEG_F;
            UNIT_H:  unit_seg = SEG_H;
            default: unit_seg = SEG_BLANK;
        endcase
    end

    assign digit_seg = (next_idx == DIGIT_UNIT_SYM) ? unit_seg : dec_seg;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n) begin
            div_cnt       <= '0;
            digit_idx     <= DIGIT_UNIT_SYM;
            pending_q     <= '0;
            pending_valid <= 1'b0;
            display_q     <= '0;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
            an            <= 4'hF;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            // Outputs are registered from the new index so they never lag it.
            if (tick) begin
                digit_idx <= next_idx;
                display_q <= next_display;
                seg       <= digit_seg;
                an        <= ~(4'b0001 << next_idx);
                dp        <= !((next_idx == DIGIT_TENS) && next_display.dp_en);
            end

            if (frame_boundary) begin
                pending_valid <= 1'b0;
            end else if (load) begin
                pending_q     <= load_cfg;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized and directed bench for bcd_display_scan, checked every cycle
// against a frame-level behavioural model of what the display should show.
module tb_bcd_display_scan;

    localparam int RD = 4;

    typedef struct {
        logic [11:0] bcd;
        logic [1:0]  unit_sel;
        logic        dp_en;
        logic        lz_en;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        load;
    logic [1:0]  unit_sel;
    logic        dp_en;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_display_scan #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .load     (load),
        .unit_sel (unit_sel),
        .dp_en    (dp_en),
        .lz_en    (lz_en),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] digit_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] unit_tab [0:3]  = '{7'h7F, 7'h46, 7'h0E, 7'h09};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        return (v > 4'd9) ? 7'h3F : digit_tab[v];
    endfunction

    // Pattern shown on display position pos (0 units .. 3 unit symbol)
    function automatic logic [6:0] model_seg(input int pos, input cfg_t c);
        int h, t;
        h = c.bcd[11:8];
        t = c.bcd[7:4];
        case (pos)
            0: return glyph(c.bcd[3:0]);
            1: return (c.lz_en && h == 0 && t == 0 && !c.dp_en) ? 7'h7F : glyph(c.bcd[7:4]);
            2: return (c.lz_en && h == 0) ? 7'h7F : glyph(c.bcd[11:8]);
            default: return unit_tab[c.unit_sel];
        endcase
    endfunction

    int         n;            // edges since reset release
    cfg_t       shown;        // value currently displayed
    cfg_t       latest;       // most recent load not yet displayed
    bit         has_latest;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;

    always @(posedge clk) begin
        if (!rst_n) begin
            n          = 0;
            shown      = '{12'h000, 2'd0, 1'b0, 1'b0};
            has_latest = 0;
            exp_seg    = 7'h7F;
            exp_dp     = 1'b1;
            exp_an     = 4'hF;
        end else begin
            n++;
            if (load) begin
                latest     = '{bcd_in, unit_sel, dp_en, lz_en};
                has_latest = 1;
            end
            if (n % RD == 0) begin
                int pos;
                pos = (n / RD - 1) % 4;
                if (pos == 0 && has_latest) begin
                    shown      = latest;
                    has_latest = 0;
                end
                exp_seg = model_seg(pos, shown);
                exp_dp  = (pos == 1 && shown.dp_en) ? 1'b0 : 1'b1;
                exp_an  = 4'hF;
                exp_an[pos] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("seg", {5'd0, seg}, {5'd0, exp_seg});
        check("dp",  {11'd0, dp}, {11'd0, exp_dp});
        check("an",  {8'd0, an},  {8'd0, exp_an});
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [11:0] v, input logic [1:0] u, input logic d, input logic z);
        @(posedge clk);
        #1;
        bcd_in = v; unit_sel = u; dp_en = d; lz_en = z; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an === target) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_an: anode %b never seen, last %b", target, an);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; bcd_in = '0; unit_sel = '0; dp_en = 1'b0; lz_en = 1'b0;

        // Reset release and first lit digit
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_tick_an", {8'd0, an}, 12'h00F);
        check("pre_tick_seg", {5'd0, seg}, 12'h07F);
        check("pre_tick_dp", {11'd0, dp}, 12'h001);
        @(negedge clk);
        check("first_an", {8'd0, an}, 12'h00E);
        check("first_seg", {5'd0, seg}, 12'h040);

        // 123 with 'C'
        do_load(12'h123, 2'd1, 1'b0, 1'b0);
        wait_an(4'b0111);
        wait_an(4'b1110); check("l123_u", {5'd0, seg}, 12'h030);
        wait_an(4'b1101); check("l123_t", {5'd0, seg}, 12'h024);
        wait_an(4'b1011); check("l123_h", {5'd0, seg}, 12'h079);
        wait_an(4'b0111); check("l123_sym", {5'd0, seg}, 12'h046);

        // Leading-zero blanking
        do_load(12'h005, 2'd2, 1'b0, 1'b1);
        wait_an(4'b0111);
        wait_an(4'b1110); check("lz_u", {5'd0, seg}, 12'h012);
        wait_an(4'b1101); check("lz_t", {5'd0, seg}, 12'h07F);
        wait_an(4'b1011); check("lz_h", {5'd0, seg}, 12'h07F);
        do_load(12'h005, 2'd2, 1'b1, 1'b1);
        wait_an(4'b0111);
        wait_an(4'b1110); check("lzdp_dp_u", {11'd0, dp}, 12'h001);
        wait_an(4'b1101); check("lzdp_t", {5'd0, seg}, 12'h040);
        check("lzdp_dp_t", {11'd0, dp}, 12'h000);
        wait_an(4'b1011); check("lzdp_h", {5'd0, seg}, 12'h07F);

        // Invalid nibble
        do_load(12'h1A3, 2'd3, 1'b0, 1'b1);
        wait_an(4'b0111);
        wait_an(4'b1101); check("inv_t", {5'd0, seg}, 12'h03F);
        wait_an(4'b1011); check("inv_h", {5'd0, seg}, 12'h079);
        wait_an(4'b0111); check("inv_sym", {5'd0, seg}, 12'h009);

        // Last-wins pending, then a load on the boundary edge itself
        wait_an(4'b1110);
        do_load(12'h111, 2'd0, 1'b0, 1'b0);
        do_load(12'h222, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && (n % 16) != 3; i++) @(posedge clk) #1;
        bcd_in = 12'h333; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("bnd_an", {8'd0, an}, 12'h00E);
        check("bnd_u", {5'd0, seg}, 12'h030);
        wait_an(4'b1011); check("bnd_h", {5'd0, seg}, 12'h030);
        do_load(12'h222, 2'd0, 1'b0, 1'b0);
        wait_an(4'b0111);
        wait_an(4'b1110); check("single_u", {5'd0, seg}, 12'h024);

        // Reset while digit 2 is lit
        wait_an(4'b1011);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_an", {8'd0, an}, 12'h00F);
        check("rst_seg", {5'd0, seg}, 12'h07F);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_an(4'b1110); check("rst_clr_u", {5'd0, seg}, 12'h040);
        wait_an(4'b1011); check("rst_clr_h", {5'd0, seg}, 12'h040);

        // Randomized traffic, including nibbles above 9 and loads on any cycle
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            load     = ($urandom_range(0, 5) == 0);
            bcd_in   = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            if ($urandom_range(0, 3) == 0) bcd_in[11:4] = 8'h00;
            unit_sel = 2'($urandom_range(0, 3));
            dp_en    = 1'($urandom_range(0, 1));
            lz_en    = 1'($urandom_range(0, 1));
            rst_n    = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk);
        #1 load = 1'b0; rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
